// File: rtl/tratador_botoes.sv
// Pushbutton front end for the stopwatch: synchronise, debounce and edge-detect four buttons,
// then run the PARADO/CONTANDO/PAUSADO mode FSM that drives the counter chain.
module tratador_botoes #(
  parameter int unsigned DEBOUNCE_CICLOS = 500000,
  parameter bit          ATIVO_BAIXO     = 1'b1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       resetI,
  input  logic       contarI,
  input  logic       pausarI,
  input  logic       pararI,
  output logic       resetC,
  output logic       contarC,
  output logic       pausarC,
  output logic       pararC,
  output logic [1:0] estado
);

  localparam int unsigned   CW      = $clog2(DEBOUNCE_CICLOS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CICLOS);

  localparam logic [1:0] PARADO   = 2'b00;
  localparam logic [1:0] CONTANDO = 2'b01;
  localparam logic [1:0] PAUSADO  = 2'b10;

  logic [3:0] btn_raw;
  logic [3:0] btn_norm;
  logic [3:0] press;

  // Bit order: 0 reset, 1 contar, 2 pausar, 3 parar.
  assign btn_raw  = {pararI, pausarI, contarI, resetI};
  assign btn_norm = ATIVO_BAIXO ? ~btn_raw : btn_raw;

  // Synchroniser output only reflects the pins after two edges out of reset.
  logic [1:0] warm_q;
  logic       warm;
  assign warm = (warm_q == 2'd2);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      warm_q <= 2'd0;
    end else if (!warm) begin
      warm_q <= warm_q + 2'd1;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_btn
    logic          sync1_q;
    logic          sync2_q;
    logic          deb_q;
    logic          deb_prev_q;
    logic          armed_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        sync1_q    <= 1'b0;
        sync2_q    <= 1'b0;
        deb_q      <= 1'b0;
        deb_prev_q <= 1'b0;
        armed_q    <= 1'b0;
        cnt_q      <= '0;
      end else begin
        sync1_q    <= btn_norm[i];
        sync2_q    <= sync1_q;
        deb_prev_q <= deb_q;
        // A button held through reset stays disarmed until it is seen released.
        if (warm && !sync2_q) begin
          armed_q <= 1'b1;
        end
        if (sync2_q == deb_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CNT_MAX) begin
          deb_q <= sync2_q;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end

    assign press[i] = deb_q & ~deb_prev_q & armed_q;
  end

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic       reset_pulse_d;

  // Fixed priority: reset > parar > pausar > contar; lower events are dropped.
  always_comb begin
    state_d       = state_q;
    reset_pulse_d = 1'b0;
    if (press[0]) begin
      reset_pulse_d = 1'b1;
      state_d       = PARADO;
    end else if (press[3]) begin
      state_d = PARADO;
    end else if (press[2]) begin
      if (state_q == CONTANDO) state_d = PAUSADO;
    end else if (press[1]) begin
      if (state_q != CONTANDO) state_d = CONTANDO;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= PARADO;
      resetC  <= 1'b0;
      contarC <= 1'b0;
      pausarC <= 1'b0;
      pararC  <= 1'b1;
    end else begin
      state_q <= state_d;
      resetC  <= reset_pulse_d;
      contarC <= (state_d == CONTANDO);
      pausarC <= (state_d == PAUSADO);
      pararC  <= (state_d == PARADO);
    end
  end

  assign estado = state_q;

endmodule

// File: tb/tb_tratador_botoes.sv
// Directed bench for tratador_botoes with DEBOUNCE_CICLOS=4, active-low buttons.
module tb_tratador_botoes;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic       resetI  = 1'b1;
  logic       contarI = 1'b1;
  logic       pausarI = 1'b1;
  logic       pararI  = 1'b1;
  logic       resetC;
  logic       contarC;
  logic       pausarC;
  logic       pararC;
  logic [1:0] estado;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  tratador_botoes #(
    .DEBOUNCE_CICLOS(4),
    .ATIVO_BAIXO    (1'b1)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .resetI (resetI),
    .contarI(contarI),
    .pausarI(pausarI),
    .pararI (pararI),
    .resetC (resetC),
    .contarC(contarC),
    .pausarC(pausarC),
    .pararC (pararC),
    .estado (estado)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic set_btn(input int idx, input logic v);
    case (idx)
      0: resetI = v;
      1: contarI = v;
      2: pausarI = v;
      default: pararI = v;
    endcase
  endtask

  task automatic press_btn(input int idx);
    @(negedge clock);
    set_btn(idx, 1'b0);
    tick(10);
    @(negedge clock);
    set_btn(idx, 1'b1);
    tick(10);
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if ({resetC, contarC, pausarC, pararC, estado} !== 6'b0001_00) begin
      failures++;
      $display("FAIL reset_hold got=%b want=000100", {resetC, contarC, pausarC, pararC, estado});
    end
    @(negedge clock);
    reset_n = 1'b1;
    tick(8);
    checks++;
    if ({resetC, contarC, pausarC, pararC, estado} !== 6'b0001_00) begin
      failures++;
      $display("FAIL reset_release got=%b want=000100", {resetC, contarC, pausarC, pararC, estado});
    end
  endtask

  task automatic test_latency;
    logic early;
    early = 1'b0;
    @(negedge clock);
    contarI = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick(1);
      if (contarC !== 1'b0 || estado !== 2'b00) early = 1'b1;
    end
    checks++;
    if (early !== 1'b0) begin
      failures++;
      $display("FAIL latency_early got=changed_before_edge7 want=unchanged");
    end
    tick(1);
    checks++;
    if (contarC !== 1'b1 || estado !== 2'b01) begin
      failures++;
      $display("FAIL latency_edge7 got=contarC=%b estado=%b want=1 01", contarC, estado);
    end
    @(negedge clock);
    contarI = 1'b1;
    tick(10);
  endtask

  task automatic test_bounce;
    int changes;
    for (int rep = 0; rep < 2; rep++) begin
      for (int k = 1; k <= 3; k++) begin
        @(negedge clock);
        pausarI = 1'b0;
        tick(k);
        @(negedge clock);
        pausarI = 1'b1;
        tick(3);
      end
    end
    checks++;
    if (estado !== 2'b01) begin
      failures++;
      $display("FAIL bounce_ignored got=%b want=01", estado);
    end
    @(negedge clock);
    pausarI = 1'b0;
    tick(20);
    checks++;
    if (estado !== 2'b10 || pausarC !== 1'b1) begin
      failures++;
      $display("FAIL hold_pause got=%b pausarC=%b want=10 1", estado, pausarC);
    end
    changes = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (estado !== 2'b10) changes++;
    end
    checks++;
    if (changes !== 0) begin
      failures++;
      $display("FAIL long_hold got=%0d_bad_cycles want=0", changes);
    end
    @(negedge clock);
    pausarI = 1'b1;
    tick(10);
  endtask

  task automatic test_state_walk;
    int         btn_seq[6];
    logic [1:0] exp_st[6];
    logic [2:0] exp_lv[6];
    btn_seq = '{3, 2, 1, 2, 1, 3};
    exp_st  = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b00};
    exp_lv  = '{3'b001, 3'b001, 3'b100, 3'b010, 3'b100, 3'b001};
    for (int s = 0; s < 6; s++) begin
      press_btn(btn_seq[s]);
      checks++;
      if (estado !== exp_st[s]) begin
        failures++;
        $display("FAIL walk_estado step=%0d got=%b want=%b", s, estado, exp_st[s]);
      end
      checks++;
      if ({contarC, pausarC, pararC} !== exp_lv[s]) begin
        failures++;
        $display("FAIL walk_levels step=%0d got=%b want=%b", s, {contarC, pausarC, pararC},
                 exp_lv[s]);
      end
    end
  endtask

  task automatic test_reset_pulse;
    int   pulses;
    logic bad;
    press_btn(1);
    checks++;
    if (estado !== 2'b01) begin
      failures++;
      $display("FAIL pulse_setup got=%b want=01", estado);
    end
    pulses = 0;
    bad    = 1'b0;
    @(negedge clock);
    resetI = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (resetC === 1'b1) begin
        pulses++;
        if (pararC !== 1'b1 || contarC !== 1'b0 || estado !== 2'b00) bad = 1'b1;
      end
    end
    checks++;
    if (pulses !== 1) begin
      failures++;
      $display("FAIL reset_pulse_count got=%0d want=1", pulses);
    end
    checks++;
    if (bad !== 1'b0) begin
      failures++;
      $display("FAIL reset_pulse_state got=not_parado want=parado_same_edge");
    end
    @(negedge clock);
    resetI = 1'b1;
    tick(10);
  endtask

  task automatic test_simultaneous;
    int pulses;
    press_btn(1);
    press_btn(2);
    checks++;
    if (estado !== 2'b10) begin
      failures++;
      $display("FAIL simul_setup got=%b want=10", estado);
    end
    @(negedge clock);
    contarI = 1'b0;
    pararI  = 1'b0;
    tick(10);
    @(negedge clock);
    contarI = 1'b1;
    pararI  = 1'b1;
    tick(10);
    checks++;
    if (estado !== 2'b00 || pararC !== 1'b1) begin
      failures++;
      $display("FAIL parar_wins got=%b want=00", estado);
    end
    pulses = 0;
    @(negedge clock);
    resetI  = 1'b0;
    contarI = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (resetC === 1'b1) pulses++;
    end
    @(negedge clock);
    resetI  = 1'b1;
    contarI = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (resetC === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 1) begin
      failures++;
      $display("FAIL reset_contar_pulse got=%0d want=1", pulses);
    end
    checks++;
    if (estado !== 2'b00) begin
      failures++;
      $display("FAIL reset_wins got=%b want=00", estado);
    end
  endtask

  task automatic test_async_reset;
    logic stay;
    press_btn(1);
    checks++;
    if (estado !== 2'b01) begin
      failures++;
      $display("FAIL async_setup got=%b want=01", estado);
    end
    @(negedge clock);
    contarI = 1'b0;
    tick(3);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({resetC, contarC, pausarC, pararC, estado} !== 6'b0001_00) begin
      failures++;
      $display("FAIL async_reset got=%b want=000100", {resetC, contarC, pausarC, pararC, estado});
    end
    @(negedge clock);
    reset_n = 1'b1;
    stay    = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (estado !== 2'b00) stay = 1'b0;
    end
    checks++;
    if (stay !== 1'b1) begin
      failures++;
      $display("FAIL held_through_reset got=event want=no_event");
    end
    @(negedge clock);
    contarI = 1'b1;
    tick(10);
    press_btn(1);
    checks++;
    if (estado !== 2'b01) begin
      failures++;
      $display("FAIL rearm_after_release got=%b want=01", estado);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_bounce();
    test_state_walk();
    test_reset_pulse();
    test_simultaneous();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
